// File: rtl/mcp_pkg.sv
// Shared types and fixed memory locations for the matrix-processor host sequencer.
package mcp_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRun,
        StRdRs,
        StRdRe,
        StCapRe,
        StDumpRd,
        StDumpWait
    } host_state_t;

    // Data-memory words holding the result-matrix start/end pointers.
    localparam int unsigned R_START_PTR_ADDR = 5;
    localparam int unsigned R_END_PTR_ADDR   = 8;

endpackage

// File: rtl/mcp_host_ctrl_if.sv
// Host link, processor and data-memory signals of the host sequencer.
interface mcp_host_ctrl_if #(
    parameter int unsigned REG_WIDTH           = 12,
    parameter int unsigned CORE_COUNT          = 4,
    parameter int unsigned DATA_MEM_ADDR_WIDTH = 12,
    parameter int unsigned CYC_WIDTH           = 32
);
    localparam int unsigned MW = REG_WIDTH * CORE_COUNT;
    localparam int unsigned AW = DATA_MEM_ADDR_WIDTH;

    logic                 go;
    logic [AW:0]          load_len;
    logic [MW-1:0]        in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic [MW-1:0]        out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_last;
    logic                 busy;
    logic                 finished;
    logic                 err;
    logic [CYC_WIDTH-1:0] run_cycles;
    logic                 proc_start;
    logic                 proc_done;
    logic [AW-1:0]        proc_addr;
    logic                 proc_wr_en;
    logic [MW-1:0]        proc_wdata;
    logic [AW-1:0]        mem_addr;
    logic                 mem_wr_en;
    logic [MW-1:0]        mem_wdata;
    logic [MW-1:0]        mem_rdata;

    modport slave (
        input  go, load_len, in_data, in_valid, out_ready, proc_done,
               proc_addr, proc_wr_en, proc_wdata, mem_rdata,
        output in_ready, out_data, out_valid, out_last, busy, finished, err,
               run_cycles, proc_start, mem_addr, mem_wr_en, mem_wdata
    );

    modport master (
        output go, load_len, in_data, in_valid, out_ready, proc_done,
               proc_addr, proc_wr_en, proc_wdata, mem_rdata,
        input  in_ready, out_data, out_valid, out_last, busy, finished, err,
               run_cycles, proc_start, mem_addr, mem_wr_en, mem_wdata
    );

endinterface

// File: rtl/mcp_host_ctrl.sv
// Host-side sequencer: loads an image into data memory, runs the processor,
// then streams the result-matrix words back to the host.
module mcp_host_ctrl
    import mcp_pkg::*;
#(
    parameter int unsigned REG_WIDTH           = 12,
    parameter int unsigned CORE_COUNT          = 4,
    parameter int unsigned DATA_MEM_ADDR_WIDTH = 12,
    parameter int unsigned CYC_WIDTH           = 32
) (
    input logic            clk,
    input logic            rstN,
    mcp_host_ctrl_if.slave bus
);
    localparam int unsigned MW = REG_WIDTH * CORE_COUNT;
    localparam int unsigned AW = DATA_MEM_ADDR_WIDTH;

    host_state_t          state_q, state_d;
    logic [AW:0]          load_cnt_q, load_cnt_d;
    logic [AW:0]          load_len_q, load_len_d;
    logic [AW-1:0]        rs_q, rs_d;
    logic [AW-1:0]        re_q, re_d;
    logic [AW-1:0]        ptr_q, ptr_d;
    logic                 err_q, err_d;
    logic                 fin_q, fin_d;
    logic                 first_q, first_d;
    logic [CYC_WIDTH-1:0] run_q, run_d;
    logic [MW-1:0]        out_data_q, out_data_d;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q    <= StIdle;
            load_cnt_q <= '0;
            load_len_q <= '0;
            rs_q       <= '0;
            re_q       <= '0;
            ptr_q      <= '0;
            err_q      <= 1'b0;
            fin_q      <= 1'b0;
            first_q    <= 1'b0;
            run_q      <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            load_len_q <= load_len_d;
            rs_q       <= rs_d;
            re_q       <= re_d;
            ptr_q      <= ptr_d;
            err_q      <= err_d;
            fin_q      <= fin_d;
            first_q    <= first_d;
            run_q      <= run_d;
            out_data_q <= out_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        load_len_d = load_len_q;
        rs_d       = rs_q;
        re_d       = re_q;
        ptr_d      = ptr_q;
        err_d      = err_q;
        fin_d      = 1'b0;
        first_d    = 1'b0;
        run_d      = run_q;
        out_data_d = out_data_q;
        unique case (state_q)
            StIdle: begin
                if (bus.go) begin
                    err_d      = 1'b0;
                    run_d      = '0;
                    load_cnt_d = '0;
                    load_len_d = bus.load_len;
                    state_d    = (bus.load_len != '0) ? StLoad : StRun;
                end
            end
            StLoad: begin
                if (bus.in_valid) begin
                    load_cnt_d = load_cnt_q + (AW + 1)'(1);
                    if (load_cnt_d == load_len_q) state_d = StRun;
                end
            end
            StRun: begin
                if (run_q != '1) run_d = run_q + CYC_WIDTH'(1);
                if (bus.proc_done) state_d = StRdRs;
            end
            StRdRs: state_d = StRdRe;
            StRdRe: begin
                rs_d    = AW'(bus.mem_rdata[REG_WIDTH-1:0]);
                state_d = StCapRe;
            end
            StCapRe: begin
                re_d = AW'(bus.mem_rdata[REG_WIDTH-1:0]);
                if (re_d < rs_q) begin
                    err_d   = 1'b1;
                    fin_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    ptr_d   = rs_q;
                    state_d = StDumpRd;
                end
            end
            StDumpRd: begin
                first_d = 1'b1;
                state_d = StDumpWait;
            end
            StDumpWait: begin
                // Read data is only valid on the first cycle here; keep a copy for stalls.
                if (first_q) out_data_d = bus.mem_rdata;
                if (bus.out_ready) begin
                    if (ptr_q == re_q) begin
                        fin_d   = 1'b1;
                        state_d = StIdle;
                    end else begin
                        ptr_d   = ptr_q + AW'(1);
                        state_d = StDumpRd;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.busy       = (state_q != StIdle);
        bus.in_ready   = (state_q == StLoad);
        bus.proc_start = (state_q == StRun);
        bus.out_valid  = (state_q == StDumpWait);
        bus.out_last   = (state_q == StDumpWait) && (ptr_q == re_q);
        bus.out_data   = (state_q == StDumpWait && first_q) ? bus.mem_rdata : out_data_q;
        bus.finished   = fin_q;
        bus.err        = err_q;
        bus.run_cycles = run_q;
        bus.mem_addr   = '0;
        bus.mem_wr_en  = 1'b0;
        bus.mem_wdata  = '0;
        case (state_q)
            StLoad: begin
                bus.mem_addr  = load_cnt_q[AW-1:0];
                bus.mem_wr_en = bus.in_valid;
                bus.mem_wdata = bus.in_data;
            end
            StRun: begin
                bus.mem_addr  = bus.proc_addr;
                bus.mem_wr_en = bus.proc_wr_en;
                bus.mem_wdata = bus.proc_wdata;
            end
            StRdRs:   bus.mem_addr = AW'(R_START_PTR_ADDR);
            StRdRe:   bus.mem_addr = AW'(R_END_PTR_ADDR);
            StDumpRd: bus.mem_addr = ptr_q;
            default:  ;
        endcase
    end

endmodule

// File: tb/tb_mcp_host_ctrl.sv
// Directed bench for mcp_host_ctrl with a memory model, a processor model and
// an output scoreboard.
module tb_mcp_host_ctrl;
    import mcp_pkg::*;

    localparam int unsigned RW = 12;
    localparam int unsigned CC = 4;
    localparam int unsigned AW = 12;
    localparam int unsigned CW = 32;
    localparam int unsigned MW = RW * CC;

    logic clk  = 1'b0;
    logic rstN = 1'b0;
    always #5 clk = ~clk;

    mcp_host_ctrl_if #(
        .REG_WIDTH(RW), .CORE_COUNT(CC), .DATA_MEM_ADDR_WIDTH(AW), .CYC_WIDTH(CW)
    ) bus ();

    mcp_host_ctrl #(
        .REG_WIDTH(RW), .CORE_COUNT(CC), .DATA_MEM_ADDR_WIDTH(AW), .CYC_WIDTH(CW)
    ) dut (
        .clk (clk),
        .rstN(rstN),
        .bus (bus)
    );

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Single-port data memory, one cycle read latency.
    logic [MW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= mem[bus.mem_addr];
    end

    // Processor model: writes res table on its first RUN cycles, done on cycle done_at.
    int unsigned   proc_cnt;
    int unsigned   done_at = 1000;
    int unsigned   res_n   = 0;
    logic [AW-1:0] res_addr [16];
    logic [MW-1:0] res_data [16];
    always @(posedge clk or negedge rstN) begin
        if (!rstN)               proc_cnt <= 0;
        else if (bus.proc_start) proc_cnt <= proc_cnt + 1;
        else                     proc_cnt <= 0;
    end
    always_comb begin
        bus.proc_done  = bus.proc_start && (proc_cnt == done_at - 1);
        bus.proc_wr_en = bus.proc_start && (proc_cnt < res_n);
        bus.proc_addr  = res_addr[proc_cnt[3:0]];
        bus.proc_wdata = res_data[proc_cnt[3:0]];
    end

    // Output side: ready driver and scoreboard monitor.
    logic [MW:0]   exp_q [$];
    logic [MW:0]   mon_e;
    logic          hold_pend = 1'b0;
    logic [MW-1:0] hold_data;
    int            fin_cnt = 0;
    int            ready_mode = 0;
    int            stall_left = 0;

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 0)      bus.out_ready = 1'b1;
            else if (ready_mode == 2) bus.out_ready = 1'b0;
            else begin
                bus.out_ready = (stall_left == 0);
                if (stall_left > 0)     stall_left--;
                else if (bus.out_valid) stall_left = $urandom_range(0, 5);
            end
        end
    end

    always @(negedge clk) begin
        if (!rstN) hold_pend = 1'b0;
        else begin
            if (bus.out_valid && hold_pend) check("out_hold", bus.out_data, hold_data);
            if (bus.out_valid && bus.out_ready) begin
                check("out_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("out_data", bus.out_data, mon_e[MW-1:0]);
                    check("out_last", bus.out_last, mon_e[MW]);
                end
            end
            hold_pend = bus.out_valid && !bus.out_ready;
            hold_data = bus.out_data;
            if (bus.finished) begin
                fin_cnt++;
                check("busy_at_fin", bus.busy, 0);
            end
        end
    end

    logic [MW-1:0] img [32];

    task automatic build_img(input int n, input int rs, input int re);
        for (int i = 0; i < n; i++) img[i] = MW'({$urandom(), $urandom()});
        img[5] = {img[5][MW-1:RW], RW'(rs)};
        img[8] = {img[8][MW-1:RW], RW'(re)};
    endtask

    task automatic set_res(input int base, input int n);
        res_n = n;
        for (int i = 0; i < n; i++) begin
            res_addr[i] = AW'(base + i);
            res_data[i] = MW'({$urandom(), $urandom()});
        end
    endtask

    task automatic push_res(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), res_data[i]});
    endtask

    task automatic start_go(input int len);
        @(negedge clk);
        bus.go       = 1'b1;
        bus.load_len = len[AW:0];
        @(negedge clk);
        bus.go = 1'b0;
    endtask

    task automatic load_img(input int n, input bit gaps, output int cycles);
        cycles = 0;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                bus.in_valid = 1'b0;
                repeat ($urandom_range(0, 3)) begin
                    @(negedge clk);
                    cycles++;
                end
            end
            bus.in_valid = 1'b1;
            bus.in_data  = img[i];
            for (int t = 0; t < 20 && !bus.in_ready; t++) begin
                @(negedge clk);
                cycles++;
            end
            check("in_ready", bus.in_ready, 1);
            @(negedge clk);
            cycles++;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_fin(input int budget, input string tag);
        int t = 0;
        while (!bus.finished && t < budget) begin
            @(negedge clk);
            t++;
        end
        check(tag, bus.finished, 1);
    endtask

    initial begin
        int cyc;
        int n;
        int fin0;
        bus.go       = 1'b0;
        bus.load_len = '0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;

        repeat (3) @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_proc_start", bus.proc_start, 0);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_finished", bus.finished, 0);
        check("rst_err", bus.err, 0);
        check("rst_mem_wr_en", bus.mem_wr_en, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_run_cycles", bus.run_cycles, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_wdata", bus.mem_wdata, 0);
        rstN = 1'b1;

        // Nominal: 9-word image, done after 50 cycles, results at 20..23.
        build_img(9, 20, 23);
        set_res(20, 4);
        done_at = 50;
        push_res(4);
        fin0 = fin_cnt;
        start_go(9);
        check("busy_after_go", bus.busy, 1);
        load_img(9, 1'b0, cyc);
        check("load_cycles", cyc, 9);
        n = 0;
        while (!bus.proc_done && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("proc_done_seen", bus.proc_done, 1);
        @(negedge clk);
        check("start_drop", bus.proc_start, 0);
        n = 1;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("done_to_valid", n, 5);
        wait_fin(100, "fin_t1");
        check("run_cycles_t1", bus.run_cycles, 50);
        check("err_t1", bus.err, 0);
        check("sb_empty_t1", exp_q.size(), 0);
        for (int i = 0; i < 9; i++) check("img_t1", mem[i], img[i]);
        @(negedge clk);
        check("fin_pulse_once", bus.finished, 0);
        check("fin_count_t1", fin_cnt - fin0, 1);

        // Zero-length load goes straight to RUN.
        set_res(20, 4);
        done_at = 10;
        push_res(4);
        @(negedge clk);
        bus.go       = 1'b1;
        bus.load_len = '0;
        check("no_wr_before_run", bus.mem_wr_en, 0);
        @(negedge clk);
        bus.go = 1'b0;
        check("run_after_go", bus.proc_start, 1);
        check("in_ready_len0", bus.in_ready, 0);
        wait_fin(100, "fin_t2");
        check("run_cycles_t2", bus.run_cycles, 10);
        check("sb_empty_t2", exp_q.size(), 0);

        // Input gaps and output stalls.
        build_img(12, 100, 106);
        set_res(100, 7);
        done_at = 12;
        push_res(7);
        ready_mode = 1;
        start_go(12);
        load_img(12, 1'b1, cyc);
        wait_fin(400, "fin_t3");
        ready_mode = 0;
        for (int i = 0; i < 12; i++) check("img_t3", mem[i], img[i]);
        check("sb_empty_t3", exp_q.size(), 0);

        // End pointer below start pointer.
        build_img(9, 30, 29);
        set_res(0, 0);
        done_at = 3;
        start_go(9);
        load_img(9, 1'b0, cyc);
        wait_fin(100, "fin_t4");
        check("err_set", bus.err, 1);
        @(negedge clk);
        check("err_sticky", bus.err, 1);

        // Reset while running.
        set_res(60, 8);
        done_at = 1000;
        start_go(0);
        check("err_cleared", bus.err, 0);
        repeat (3) @(negedge clk);
        check("wr_before_rst", bus.mem_wr_en, 1);
        #2 rstN = 1'b0;
        #1;
        check("rst_run_proc_start", bus.proc_start, 0);
        check("rst_run_mem_wr_en", bus.mem_wr_en, 0);
        check("rst_run_busy", bus.busy, 0);
        check("rst_run_cycles", bus.run_cycles, 0);
        @(negedge clk);
        rstN = 1'b1;

        // Reset while presenting a result word.
        build_img(9, 50, 52);
        set_res(50, 3);
        done_at = 6;
        push_res(3);
        ready_mode = 2;
        start_go(9);
        load_img(9, 1'b0, cyc);
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("valid_before_rst", bus.out_valid, 1);
        #2 rstN = 1'b0;
        #1;
        check("rst_dump_out_valid", bus.out_valid, 0);
        check("rst_dump_out_data", bus.out_data, 0);
        check("rst_dump_out_last", bus.out_last, 0);
        check("rst_dump_busy", bus.busy, 0);
        exp_q.delete();
        @(negedge clk);
        rstN = 1'b1;
        ready_mode = 0;

        // Normal sequence after the aborted one.
        set_res(50, 3);
        done_at = 6;
        push_res(3);
        start_go(0);
        wait_fin(100, "fin_t5");
        check("sb_empty_t5", exp_q.size(), 0);

        // go held high: back-to-back sequences, one per IDLE visit.
        push_res(3);
        push_res(3);
        @(negedge clk);
        fin0         = fin_cnt;
        bus.go       = 1'b1;
        bus.load_len = '0;
        @(negedge clk);
        wait_fin(200, "fin_t6a");
        @(negedge clk);
        check("restart_after_fin", bus.busy, 1);
        bus.go = 1'b0;
        wait_fin(200, "fin_t6b");
        repeat (5) @(negedge clk);
        check("fin_count_t6", fin_cnt - fin0, 2);
        check("idle_after_t6", bus.busy, 0);
        check("sb_empty_t6", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no completion, expected finish before timeout");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mcp_host_ctrl.md
# mcp_host_ctrl

Host-side sequencer for the multi-core matrix processor. It owns the shared data memory port. It streams a host-supplied image into data memory, asserts `start` to the processor and hands it the memory port until `done`. It then reads the result-matrix pointers at addresses 5/8 and streams result words R_start..R_end back to the host. It sits between the host link (UART/DMA bridge), the `multi_core_processor` instance and the single-port data memory, which has 1-cycle read latency.

## Interface
Parameters:
- `REG_WIDTH`, 12, per-core word width
- `CORE_COUNT`, 4, cores; memory word = `REG_WIDTH*CORE_COUNT` (MW)
- `DATA_MEM_ADDR_WIDTH`, 12, data memory address width (AW)
- `CYC_WIDTH`, 32, run-cycle counter width

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `rstN`  in  1  asynchronous, active-low reset
- `go`  in  1  start a load/run/dump sequence (sampled in IDLE only)
- `load_len`  in  AW+1  words to load, sampled with `go`
- `in_data`  in  MW  load word; `in_valid` in 1; `in_ready` out 1
- `out_data`  out  MW  result word; `out_valid` out 1; `out_ready` in 1; `out_last` out 1
- `busy`  out  1  state != IDLE
- `finished`  out  1  one-cycle pulse on sequence completion
- `err`  out  1  sticky: R_end < R_start; cleared on next accepted `go`
- `run_cycles`  out  CYC_WIDTH  cycles spent in RUN, saturating
- `proc_start`  out  1  to processor `start`
- `proc_done`  in  1  from processor `done`
- `proc_addr`  in  AW; `proc_wr_en`  in  1; `proc_wdata`  in  MW  processor memory request
- `mem_addr`  out  AW; `mem_wr_en`  out  1; `mem_wdata`  out  MW  to data memory
- `mem_rdata`  in  MW  memory read data, valid the cycle after the address

## Operation
- States: IDLE, LOAD, RUN, RD_RS, RD_RE, CAP_RE, DUMP_RD, DUMP_WAIT.
- IDLE: `go`=1 → clear `err`, `run_cycles`, load counter; go to LOAD if `load_len`≠0, else RUN.
- LOAD: `in_ready`=1. Each `in_valid&in_ready` drives the same cycle `mem_wr_en`=1, `mem_addr`=load_addr (from 0), `mem_wdata`=`in_data`. After the `load_len`-th word → RUN.
- RUN: `proc_start`=1. Memory port is a combinational pass-through of `proc_addr/proc_wr_en/proc_wdata`. `run_cycles` increments each cycle and saturates at all-ones. First cycle with `proc_done`=1 → RD_RS, and `proc_start` drops.
- RD_RS: `mem_addr`=5 → RD_RE.
- RD_RE: `mem_addr`=8; capture `mem_rdata[REG_WIDTH-1:0]` as rs → CAP_RE.
- CAP_RE: capture re. If re<rs, set `err`, pulse `finished` → IDLE. Otherwise ptr=rs → DUMP_RD.
- DUMP_RD: `mem_addr`=ptr → DUMP_WAIT.
- DUMP_WAIT: `out_data` is loaded from `mem_rdata` on entry and held; `out_valid`=1; `out_last`=(ptr==re). On `out_ready`: if last, pulse `finished` → IDLE; else ptr+1 → DUMP_RD.
- Outside LOAD/RUN: `mem_wr_en`=0, `mem_wdata`=0. `mem_addr`=0 except where driven above.
- `go` is ignored while busy.
- Address arithmetic is AW bits. Pointers are truncated to AW. ptr never wraps because re ≤ 2^AW−1 is checked by equality.

## Timing
- Reset (async, `rstN`=0): state IDLE. `proc_start`, `in_ready`, `out_valid`, `out_last`, `busy`, `finished`, `err`, `mem_wr_en` = 0; `out_data`, `run_cycles`, `mem_addr`, `mem_wdata` = 0.
- Reset mid-sequence aborts immediately: `proc_start` and `mem_wr_en` go low asynchronously, with no partial output stream.
- `go` accepted at edge N: `busy`=1 from N+1.
- LOAD sustains 1 word/cycle. Ready/valid has no combinational path from `in_valid` to `in_ready`.
- `proc_done` seen at edge N: `proc_start`=0 from N+1; first `out_valid` at N+5.
- Dump throughput is 1 word per 2 cycles at full `out_ready`. `out_data` is stable while `out_valid`&!`out_ready`.
- `finished` is high for exactly the cycle after the final handshake (or the error decision); `busy` is 0 in that same cycle.

## Structure
- Package `mcp_pkg`: state enum `host_state_t`; constants `R_START_PTR_ADDR`=5 and `R_END_PTR_ADDR`=8. Widths are derived from the parameters.
- Single module with no sub-modules. The saturating counter is inline.

## Test plan
- `load_len`=9 words, processor model asserts `done` after 50 RUN cycles, mem[5]=20, mem[8]=23 → 4 words from addresses 20..23 out; `out_last` on the 4th; `run_cycles`=50; one `finished` pulse.
- `load_len`=0 → RUN entered the cycle after `go`, with no `mem_wr_en` before `proc_start`.
- Random `in_valid` gaps and `out_ready` stalls of 0–5 cycles → loaded image matches the input order; `out_data` is held during stalls and no word is dropped or duplicated.
- mem[5]=30, mem[8]=29 → no `out_valid`; `err`=1; `finished` pulses; next `go` clears `err`.
- `rstN` pulsed low in RUN and in DUMP_WAIT → all outputs return to reset values asynchronously; a following `go` completes normally.
- `go` held high through an entire sequence → exactly one sequence per IDLE visit; a new sequence starts the cycle after `finished`.
